// File: rtl/tile_pkg.sv
// Shared tile-level types and constants for the tile network datapath.
package tile_pkg;

   localparam int NREQ_DEF = 4;
   localparam int XW       = 4;
   localparam int QW       = 8;

   typedef logic [XW-1:0][QW-1:0] vec_t;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

endpackage

// File: rtl/tile_out_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first eligible index after rr_ptr, modulo NREQ.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] eligible,
   input  logic [IDW-1:0]  rr_ptr,
   output logic            any,
   output logic [IDW-1:0]  idx
);

   function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int k);
      return IDW'((int'(base) + k) % NREQ);
   endfunction

   // Walk from the farthest candidate back to rr_ptr+1 so the nearest eligible one wins.
   always_comb begin
      any = 1'b0;
      idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         if (eligible[wrap_idx(rr_ptr, k)]) begin
            any = 1'b1;
            idx = wrap_idx(rr_ptr, k);
         end
      end
   end

endmodule

// File: rtl/tile_out_arbiter.sv
// Round-robin arbiter sharing the tile-to-network vector port; grant held for the whole serialization.
//   state | meaning
//   IDLE  | no grant; pick next eligible requester after rr_ptr
//   LOCK  | grant_id_o owns the port until handshake or flush
module tile_out_arbiter
   import tile_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int CNTW = 16,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                             clk_tl,
   input  logic                             rstn_tl,
   input  logic                             flush_i,
   input  logic [NREQ-1:0]                  req_mask_i,
   input  logic [NREQ-1:0][XW-1:0][QW-1:0]  req_data_i,
   input  logic [NREQ-1:0]                  req_valid_i,
   output logic [NREQ-1:0]                  req_ready_o,
   output logic [XW-1:0][QW-1:0]            mio_data_o,
   output logic                             mio_valid_o,
   input  logic                             mio_ready_i,
   output logic [IDW-1:0]                   grant_id_o,
   output logic                             busy_o,
   output logic [CNTW-1:0]                  xfer_cnt_o
);

   arb_state_e      state_q, state_d;
   logic [IDW-1:0]  rr_ptr_q;
   logic [IDW-1:0]  grant_q;
   logic [CNTW-1:0] xfer_cnt_q;
   logic [NREQ-1:0] eligible;
   logic            pick_any;
   logic [IDW-1:0]  pick_idx;
   logic            lock;
   logic            handshake;
   vec_t            sel_data;

   assign eligible = req_valid_i & req_mask_i;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_pick (
      .eligible (eligible),
      .rr_ptr   (rr_ptr_q),
      .any      (pick_any),
      .idx      (pick_idx)
   );

   assign lock = (state_q == LOCK);

   // Grant is sticky: mask changes and valid drops from the owner do not release it.
   always_comb begin
      sel_data    = '0;
      mio_valid_o = 1'b0;
      req_ready_o = '0;
      if (lock) begin
         sel_data              = req_data_i[grant_q];
         mio_valid_o           = req_valid_i[grant_q];
         req_ready_o[grant_q]  = mio_ready_i;
      end
   end

   assign mio_data_o = sel_data;
   assign handshake  = mio_valid_o & mio_ready_i;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick_any)  state_d = LOCK;
         LOCK:    if (handshake) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush_i) state_d = IDLE;
   end

   always_ff @(posedge clk_tl or negedge rstn_tl) begin
      if (!rstn_tl) begin
         state_q    <= IDLE;
         rr_ptr_q   <= IDW'(NREQ - 1);
         grant_q    <= '0;
         xfer_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (!flush_i) begin
            if (!lock && pick_any) grant_q <= pick_idx;
            if (handshake) begin
               rr_ptr_q   <= grant_q;
               xfer_cnt_q <= xfer_cnt_q + CNTW'(1);
            end
         end
      end
   end

   assign grant_id_o = grant_q;
   assign busy_o     = lock;
   assign xfer_cnt_o = xfer_cnt_q;

endmodule

// File: tb/tb_tile_out_arbiter.sv
// Directed bench for tile_out_arbiter with an expected-grant scoreboard.
module tb_tile_out_arbiter;

   localparam int NREQ = 4;
   localparam int CNTW = 16;

   logic                   clk_tl = 1'b0;
   logic                   rstn_tl;
   logic                   flush_i;
   logic [NREQ-1:0]        req_mask_i;
   logic [NREQ-1:0][3:0][7:0] req_data_i;
   logic [NREQ-1:0]        req_valid_i;
   logic [NREQ-1:0]        req_ready_o;
   logic [3:0][7:0]        mio_data_o;
   logic                   mio_valid_o;
   logic                   mio_ready_i;
   logic [1:0]             grant_id_o;
   logic                   busy_o;
   logic [CNTW-1:0]        xfer_cnt_o;

   logic [31:0]     vec_data [NREQ];
   int              exp_q [$];
   logic [CNTW-1:0] exp_cnt;
   int              n_asserts = 0;
   int              n_fail    = 0;

   tile_out_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
      .clk_tl      (clk_tl),
      .rstn_tl     (rstn_tl),
      .flush_i     (flush_i),
      .req_mask_i  (req_mask_i),
      .req_data_i  (req_data_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .mio_data_o  (mio_data_o),
      .mio_valid_o (mio_valid_o),
      .mio_ready_i (mio_ready_i),
      .grant_id_o  (grant_id_o),
      .busy_o      (busy_o),
      .xfer_cnt_o  (xfer_cnt_o)
   );

   always #5 clk_tl = ~clk_tl;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_tl);
      #1;
   endtask

   task automatic wait_busy();
      for (int b = 0; b < 20 && busy_o !== 1'b1; b++) tick();
      chk(64'(busy_o), 64'd1, "grant_wait");
   endtask

   // Hold the port for nchan cycles, pulse ready on the last one and score the vector.
   task automatic serve(input int nchan);
      int exp;
      wait_busy();
      repeat (nchan - 1) tick();
      mio_ready_i = 1'b1;
      #3;
      if (exp_q.size() == 0) begin
         chk(64'd0, 64'd1, "sb_empty");
         exp = 0;
      end else begin
         exp = exp_q.pop_front();
      end
      chk(64'(grant_id_o), 64'(exp), "grant_id");
      chk(64'(mio_valid_o), 64'd1, "mio_valid");
      chk(64'(mio_data_o), 64'(vec_data[exp]), "mio_data");
      chk(64'(req_ready_o), 64'(4'b0001 << exp), "req_ready_hs");
      tick();
      mio_ready_i = 1'b0;
      exp_cnt     = exp_cnt + 16'd1;
      #1;
      chk(64'(busy_o), 64'd0, "idle_gap");
      chk(64'(xfer_cnt_o), 64'(exp_cnt), "xfer_cnt");
      chk(64'(req_ready_o), 64'd0, "req_ready_after");
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         vec_data[i]   = 32'hA500_0000 + 32'(i) * 32'h0011_2233;
         req_data_i[i] = vec_data[i];
      end
      exp_cnt     = '0;
      rstn_tl     = 1'b0;
      flush_i     = 1'b0;
      mio_ready_i = 1'b0;
      req_mask_i  = 4'b1111;
      req_valid_i = 4'b1111;

      // Reset with every requester valid
      repeat (3) tick();
      #3;
      chk(64'(mio_valid_o), 64'd0, "rst_valid");
      chk(64'(busy_o), 64'd0, "rst_busy");
      chk(64'(grant_id_o), 64'd0, "rst_grant");
      chk(64'(req_ready_o), 64'd0, "rst_ready");
      chk(64'(mio_data_o), 64'd0, "rst_data");
      chk(64'(xfer_cnt_o), 64'd0, "rst_cnt");
      tick();
      rstn_tl = 1'b1;
      exp_q.push_back(0);
      tick();
      chk(64'(grant_id_o), 64'd0, "first_grant");
      chk(64'(busy_o), 64'd1, "first_busy");

      // Requesters 0,1,3 valid: rotation 0,1,3,0,1,3
      req_valid_i = 4'b1011;
      exp_q.push_back(1); exp_q.push_back(3);
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
      repeat (6) serve(7);
      chk(64'(xfer_cnt_o), 64'd6, "six_xfers");

      // Req 2 granted, then masked mid-LOCK; it completes and is skipped afterwards
      req_valid_i = 4'b0100;
      wait_busy();
      chk(64'(grant_id_o), 64'd2, "grant_req2");
      req_mask_i  = 4'b1011;
      req_valid_i = 4'b0111;
      exp_q.push_back(2);
      serve(3);
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
      repeat (3) serve(2);

      // Req 1 alone, held 20 cycles without ready
      req_mask_i  = 4'b1111;
      req_valid_i = 4'b0010;
      wait_busy();
      for (int c = 0; c < 20; c++) begin
         #3;
         chk(64'(mio_data_o), 64'(vec_data[1]), "hold_data");
         chk(64'(req_ready_o), 64'd0, "hold_ready");
         tick();
      end
      exp_q.push_back(1);
      serve(1);
      exp_q.push_back(1);
      serve(1);

      // Flush with ready in LOCK: not counted, rr_ptr kept, same winner next
      req_valid_i = 4'b1001;
      wait_busy();
      chk(64'(grant_id_o), 64'd3, "flush_grant");
      mio_ready_i = 1'b1;
      flush_i     = 1'b1;
      tick();
      mio_ready_i = 1'b0;
      flush_i     = 1'b0;
      #1;
      chk(64'(busy_o), 64'd0, "flush_idle");
      chk(64'(xfer_cnt_o), 64'(exp_cnt), "flush_cnt");
      exp_q.push_back(3);
      serve(2);

      // Async reset in the middle of LOCK
      req_valid_i = 4'b0001;
      wait_busy();
      rstn_tl = 1'b0;
      #1;
      chk(64'(mio_valid_o), 64'd0, "arst_valid");
      chk(64'(busy_o), 64'd0, "arst_busy");
      chk(64'(mio_data_o), 64'd0, "arst_data");
      chk(64'(xfer_cnt_o), 64'd0, "arst_cnt");
      exp_cnt     = '0;
      req_valid_i = 4'b0000;
      tick();
      rstn_tl = 1'b1;
      tick();

      // Counter wrap from 16'hFFFF
      force dut.xfer_cnt_q = 16'hFFFF;
      tick();
      release dut.xfer_cnt_q;
      tick();
      chk(64'(xfer_cnt_o), 64'hFFFF, "preload_cnt");
      exp_cnt     = 16'hFFFF;
      req_valid_i = 4'b0001;
      exp_q.push_back(0);
      serve(2);
      chk(64'(xfer_cnt_o), 64'd0, "wrap_cnt");
      chk(64'(exp_q.size()), 64'd0, "sb_drained");

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
